// File: rtl/div3_arbiter.sv
// div3_arbiter: round-robin front end that shares one divide-by-3 datapath among NUM_REQ requesters.
// Results return in issue order, routed by an ID FIFO of requester indices.
//
// state | meaning
// RUN   | requests accepted while the ID FIFO has room
// DRAIN | no new requests; outstanding results still delivered
// DONE  | nothing outstanding; o_drain_done high until i_drain drops
module div3_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DWIDTH     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0]     i_req_n,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DWIDTH-1:0]             o_rsp_div3,
  input  logic                          i_drain,
  output logic                          o_drain_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_inflight,
  output logic                          o_err,
  output logic [DWIDTH-1:0]             o_dut_n,
  output logic                          o_dut_n_valid,
  input  logic [DWIDTH-1:0]             i_dut_div3,
  input  logic                          i_dut_div3_valid
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = IDW + 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [AW-1:0]       wr_q, wr_d;
  logic [AW-1:0]       rd_q, rd_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IDW-1:0]      fifo_q [FIFO_DEPTH];
  logic                dut_valid_q;
  logic [DWIDTH-1:0]   dut_n_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic [DWIDTH-1:0]   rsp_div3_q;
  logic                err_q;

  logic [NUM_REQ-1:0]  rot;
  logic [IDW-1:0]      off;
  logic                found;
  logic [SW-1:0]       gnt_sum;
  logic [IDW-1:0]      gnt_idx;
  logic [DWIDTH-1:0]   sel_n;
  logic                issue_ok;
  logic                handshake;
  logic                pop;
  logic                underflow;

  // Rotate the valids so bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot   = NUM_REQ'({i_req_valid, i_req_valid} >> ptr_q);
    off   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = IDW'(i);
      end
    end
    gnt_sum = {1'b0, ptr_q} + {1'b0, off};
    if (gnt_sum >= SW'(NUM_REQ)) begin
      gnt_idx = IDW'(gnt_sum - SW'(NUM_REQ));
    end else begin
      gnt_idx = IDW'(gnt_sum);
    end
  end

  always_comb begin
    sel_n = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_n = i_req_n[i*DWIDTH +: DWIDTH];
      end
    end
  end

  assign issue_ok    = (state_q == RUN) && (cnt_q < CW'(FIFO_DEPTH));
  assign o_req_ready = (issue_ok && found) ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign handshake   = |(i_req_valid & o_req_ready);
  assign pop         = i_dut_div3_valid && (cnt_q != '0);
  assign underflow   = i_dut_div3_valid && (cnt_q == '0);

  always_comb begin
    ptr_d = ptr_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (handshake) begin
      ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      wr_d  = (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    case ({handshake, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // A result arriving in the same cycle blocks DRAIN->DONE, even if it underflows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (i_drain) state_d = DRAIN;
      DRAIN: begin
        if (!i_drain) begin
          state_d = RUN;
        end else if ((cnt_q == '0) && !i_dut_div3_valid) begin
          state_d = DONE;
        end
      end
      DONE:    if (!i_drain) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      dut_valid_q <= 1'b0;
      dut_n_q     <= '0;
      rsp_valid_q <= '0;
      rsp_div3_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      dut_valid_q <= handshake;
      if (handshake) begin
        dut_n_q <= sel_n;
      end
      rsp_valid_q <= pop ? (NUM_REQ'(1) << fifo_q[rd_q]) : '0;
      if (pop) begin
        rsp_div3_q <= i_dut_div3;
      end
      if (underflow) begin
        err_q <= 1'b1;
      end
    end
  end

  // Entries are only read after being written, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (handshake) begin
      fifo_q[wr_q] <= gnt_idx;
    end
  end

  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_div3    = rsp_div3_q;
  assign o_drain_done  = (state_q == DONE);
  assign o_inflight    = cnt_q;
  assign o_err         = err_q;
  assign o_dut_n       = dut_n_q;
  assign o_dut_n_valid = dut_valid_q;

endmodule

// File: tb/tb_div3_arbiter.sv
// Testbench for div3_arbiter: divider stub, handshake monitor feeding a response scoreboard,
// and a directed sequence of steps.
module tb_div3_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int FD = 8;

  logic                  clk;
  logic                  rst;
  logic [NR-1:0]         i_req_valid;
  logic [NR*DW-1:0]      i_req_n;
  logic [NR-1:0]         o_req_ready;
  logic [NR-1:0]         o_rsp_valid;
  logic [DW-1:0]         o_rsp_div3;
  logic                  i_drain;
  logic                  o_drain_done;
  logic [$clog2(FD):0]   o_inflight;
  logic                  o_err;
  logic [DW-1:0]         o_dut_n;
  logic                  o_dut_n_valid;
  logic [DW-1:0]         i_dut_div3;
  logic                  i_dut_div3_valid;

  div3_arbiter #(.NUM_REQ(NR), .DWIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req_valid      (i_req_valid),
    .i_req_n          (i_req_n),
    .o_req_ready      (o_req_ready),
    .o_rsp_valid      (o_rsp_valid),
    .o_rsp_div3       (o_rsp_div3),
    .i_drain          (i_drain),
    .o_drain_done     (o_drain_done),
    .o_inflight       (o_inflight),
    .o_err            (o_err),
    .o_dut_n          (o_dut_n),
    .o_dut_n_valid    (o_dut_n_valid),
    .i_dut_div3       (i_dut_div3),
    .i_dut_div3_valid (i_dut_div3_valid)
  );

  typedef struct {
    int            id;
    logic [DW-1:0] q;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            grants[$];
  logic [DW-1:0] div_q[$];

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  int rsp_cnt = 0;

  logic          exp_dn_valid = 1'b0;
  logic [DW-1:0] exp_dn = '0;
  logic [NR-1:0] hs;

  bit stub_hold = 1'b0;
  bit stub_inject = 1'b0;
  int stub_release = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Divider stub: quotient of each issued operand, in order; can hold results or inject a stray one.
  initial begin
    i_dut_div3_valid = 1'b0;
    i_dut_div3 = '0;
    forever begin
      @(negedge clk);
      #1;
      i_dut_div3_valid = 1'b0;
      if (!rst) begin
        div_q.delete();
      end else begin
        if (o_dut_n_valid === 1'b1) div_q.push_back(o_dut_n);
        if (stub_inject) begin
          i_dut_div3_valid = 1'b1;
          i_dut_div3 = 32'd55;
          stub_inject = 1'b0;
        end else if (div_q.size() > 0 && (!stub_hold || stub_release > 0)) begin
          i_dut_div3 = div_q.pop_front() / 3;
          i_dut_div3_valid = 1'b1;
          if (stub_hold) stub_release--;
        end
      end
    end
  end

  // Monitor: records handshakes, checks the operand strobe and scores every response.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        exp_dn_valid = 1'b0;
      end else begin
        check("ready_onehot0", 64'($onehot0(o_req_ready)), 64'(1));
        check("dut_n_valid", 64'(o_dut_n_valid), 64'(exp_dn_valid));
        if (exp_dn_valid) check("dut_n", 64'(o_dut_n), 64'(exp_dn));
        if (o_rsp_valid !== '0) begin
          rsp_cnt++;
          if (sb.size() == 0) begin
            check("rsp_unexpected", 64'(o_rsp_valid), 64'(0));
          end else begin
            e = sb.pop_front();
            check("rsp_id", 64'(o_rsp_valid), 64'(NR'(1) << e.id));
            check("rsp_div3", 64'(o_rsp_div3), 64'(e.q));
          end
        end
        hs = i_req_valid & o_req_ready;
        exp_dn_valid = (hs != '0);
        for (int k = 0; k < NR; k++) begin
          if (hs[k]) begin
            exp_dn = i_req_n[k*DW +: DW];
            sb.push_back('{id: k, q: exp_dn / 3});
            grants.push_back(k);
            acc_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic issue(input int k, input logic [DW-1:0] n);
    @(negedge clk);
    i_req_valid = NR'(1) << k;
    i_req_n[k*DW +: DW] = n;
    #2 check("issue_ready", 64'(o_req_ready), 64'(NR'(1) << k));
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (o_rsp_valid !== '0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || o_inflight !== '0) && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    check(tag, 64'(sb.size() == 0 && o_inflight === '0), 64'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
    check({tag, "_rsp_div3"}, 64'(o_rsp_div3), 64'(0));
    check({tag, "_dut_n_valid"}, 64'(o_dut_n_valid), 64'(0));
    check({tag, "_dut_n"}, 64'(o_dut_n), 64'(0));
    check({tag, "_drain_done"}, 64'(o_drain_done), 64'(0));
    check({tag, "_err"}, 64'(o_err), 64'(0));
    check({tag, "_inflight"}, 64'(o_inflight), 64'(0));
  endtask

  bit got;

  initial begin
    rst = 1'b0;
    i_req_valid = '0;
    i_req_n = '0;
    i_drain = 1'b0;

    // Reset values
    @(negedge clk);
    #2 check_reset_outputs("reset");
    check("reset_ready", 64'(o_req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Fairness: all four valid, ptr starts at 0
    grants.delete();
    rsp_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < NR; k++) i_req_n[k*DW +: DW] = DW'(3 * k + 1);
    i_req_valid = 4'hF;
    repeat (12) @(negedge clk);
    i_req_valid = '0;
    wait_idle("fair_idle");
    check("fair_grant_count", 64'(grants.size()), 64'(12));
    for (int i = 0; i < 12; i++) check("fair_grant_order", 64'(grants[i]), 64'(i % 4));
    check("fair_rsp_count", 64'(rsp_cnt), 64'(12));

    // Single request from requester 2
    @(negedge clk);
    i_req_n[2*DW +: DW] = 32'd99;
    i_req_valid = 4'b0100;
    #2 check("single_ready", 64'(o_req_ready), 64'(4'b0100));
    @(negedge clk);
    i_req_valid = '0;
    #2 check("single_dut_n_valid", 64'(o_dut_n_valid), 64'(1));
    check("single_dut_n", 64'(o_dut_n), 64'(99));
    wait_rsp(got);
    check("single_rsp_seen", 64'(got), 64'(1));
    check("single_rsp_valid", 64'(o_rsp_valid), 64'(4'b0100));
    check("single_rsp_div3", 64'(o_rsp_div3), 64'(33));
    @(negedge clk);
    #2 check("single_rsp_hold_valid", 64'(o_rsp_valid), 64'(0));
    check("single_rsp_hold_data", 64'(o_rsp_div3), 64'(33));
    wait_idle("single_idle");

    // Full: stub holds every result
    stub_hold = 1'b1;
    acc_cnt = 0;
    @(negedge clk);
    for (int k = 0; k < NR; k++) i_req_n[k*DW +: DW] = DW'(100 + 7 * k);
    i_req_valid = 4'hF;
    repeat (12) @(negedge clk);
    #2 check("full_accepts", 64'(acc_cnt), 64'(8));
    check("full_inflight", 64'(o_inflight), 64'(8));
    check("full_ready", 64'(o_req_ready), 64'(0));
    stub_release = 1;
    repeat (4) @(negedge clk);
    #2 check("full_resume_accepts", 64'(acc_cnt), 64'(9));
    check("full_resume_inflight", 64'(o_inflight), 64'(8));
    @(negedge clk);
    i_req_valid = '0;
    stub_hold = 1'b0;
    wait_idle("full_idle");

    // Drain with five outstanding
    stub_hold = 1'b1;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) issue(i % NR, DW'(1000 + 5 * i));
    @(negedge clk);
    i_req_valid = '0;
    i_drain = 1'b1;
    @(negedge clk);
    i_req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #2 check("drain_inflight", 64'(o_inflight), 64'(5));
    check("drain_ready", 64'(o_req_ready), 64'(0));
    check("drain_not_done", 64'(o_drain_done), 64'(0));
    rsp_cnt = 0;
    stub_hold = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      #2;
      if (o_drain_done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check("drain_done_seen", 64'(got), 64'(1));
    check("drain_accepts", 64'(acc_cnt), 64'(5));
    check("drain_rsp_count", 64'(rsp_cnt), 64'(5));
    check("drain_done_inflight", 64'(o_inflight), 64'(0));
    @(negedge clk);
    i_drain = 1'b0;
    repeat (3) @(negedge clk);
    #2 check("run_done_low", 64'(o_drain_done), 64'(0));
    check("run_accepts_resume", 64'(acc_cnt > 5), 64'(1));
    @(negedge clk);
    i_req_valid = '0;
    wait_idle("drain_idle");

    // Underflow: stray result with nothing outstanding
    check("pre_underflow_err", 64'(o_err), 64'(0));
    @(negedge clk);
    stub_inject = 1'b1;
    @(negedge clk);
    #2 check("underflow_err", 64'(o_err), 64'(1));
    check("underflow_rsp_valid", 64'(o_rsp_valid), 64'(0));
    check("underflow_inflight", 64'(o_inflight), 64'(0));
    repeat (3) @(negedge clk);
    #2 check("underflow_err_sticky", 64'(o_err), 64'(1));

    // Reset with three outstanding
    stub_hold = 1'b1;
    for (int i = 0; i < 3; i++) issue(i, DW'(30 + i));
    @(negedge clk);
    i_req_valid = '0;
    @(negedge clk);
    #2 check("midrst_inflight", 64'(o_inflight), 64'(3));
    @(negedge clk);
    #3 rst = 1'b0;
    sb.delete();
    #1 check_reset_outputs("midrst");
    stub_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1, 32'd7);
    @(negedge clk);
    i_req_valid = '0;
    #2;
    wait_rsp(got);
    check("midrst_rsp_seen", 64'(got), 64'(1));
    check("midrst_rsp_valid", 64'(o_rsp_valid), 64'(4'b0010));
    check("midrst_rsp_div3", 64'(o_rsp_div3), 64'(2));
    check("midrst_err", 64'(o_err), 64'(0));
    wait_idle("midrst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
